// File: rtl/bus_arb_pkg.sv
//------------------------------------------------------------------------------
// bus_arb_pkg - shared types for the unified inst/data bus arbiter. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bus_arb_pkg;
  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;
endpackage

`default_nettype wire

// File: rtl/arb_tag_fifo.sv
//------------------------------------------------------------------------------
// arb_tag_fifo - in-order FIFO of requester tags for reads in flight. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module arb_tag_fifo
  import bus_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  owner_t                       i_tag,
  input  logic                         i_pop,
  output owner_t                       o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [c_cnt_w-1:0] r_count;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  owner_t             r_tags [DEPTH];
  logic               w_push;
  logic               w_pop;

  function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == c_cnt_w'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_tags[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_tags[r_wr_ptr] <= i_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/unified_bus_arbiter.sv
//------------------------------------------------------------------------------
// unified_bus_arbiter - shares one wait/valid memory bus between fetch and data.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module unified_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [31:0]                          inst_address,
  input  logic                                 inst_read_enable,
  output logic [31:0]                          inst_read_data,
  output logic                                 inst_wait_req,
  output logic                                 inst_valid,
  input  logic [31:0]                          data_address,
  input  logic [31:0]                          data_write_data,
  input  logic [3:0]                           data_byte_enable,
  input  logic                                 data_read_enable,
  input  logic                                 data_write_enable,
  output logic [31:0]                          data_read_data,
  output logic                                 data_wait_req,
  output logic                                 data_valid,
  output logic [31:0]                          mem_address,
  output logic [31:0]                          mem_write_data,
  output logic [3:0]                           mem_byte_enable,
  output logic                                 mem_read_enable,
  output logic                                 mem_write_enable,
  input  logic [31:0]                          mem_read_data,
  input  logic                                 mem_wait_req,
  input  logic                                 mem_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_count,
  output logic                                 protocol_error
);

  localparam int c_stv_w = $clog2(STARVE_LIMIT + 1);

  logic               r_lock_valid;
  owner_t             r_lock_owner;
  logic [c_stv_w-1:0] r_starve_cnt;
  logic               r_protocol_error;

  logic   w_has_owner;
  owner_t w_owner;
  logic   w_sel_inst;
  logic   w_sel_data;
  logic   w_is_read;
  logic   w_is_write;
  logic   w_read_blocked;
  logic   w_accept;
  logic   w_owner_wait;
  logic   w_pop;
  logic   w_fifo_full;
  logic   w_fifo_empty;
  owner_t w_head;

  // A locked owner keeps the bus until accepted, regardless of priority.
  always_comb begin
    w_has_owner = 1'b0;
    w_owner     = OWNER_DATA;
    if (r_lock_valid) begin
      w_has_owner = 1'b1;
      w_owner     = r_lock_owner;
    end else if (inst_read_enable &&
                 (!(data_read_enable || data_write_enable) ||
                  r_starve_cnt == c_stv_w'(STARVE_LIMIT))) begin
      w_has_owner = 1'b1;
      w_owner     = OWNER_INST;
    end else if (data_read_enable || data_write_enable) begin
      w_has_owner = 1'b1;
      w_owner     = OWNER_DATA;
    end
  end

  assign w_sel_inst     = w_has_owner & (w_owner == OWNER_INST);
  assign w_sel_data     = w_has_owner & (w_owner == OWNER_DATA);
  assign w_is_read      = (w_sel_inst & inst_read_enable) | (w_sel_data & data_read_enable);
  assign w_is_write     = w_sel_data & data_write_enable;
  assign w_read_blocked = w_is_read & w_fifo_full;
  assign w_accept       = (w_is_read | w_is_write) & ~mem_wait_req & ~w_read_blocked;
  assign w_owner_wait   = mem_wait_req | w_read_blocked;

  assign mem_address      = w_sel_inst ? inst_address : data_address;
  assign mem_write_data   = w_sel_data ? data_write_data : 32'h0;
  assign mem_byte_enable  = w_sel_data ? data_byte_enable : 4'b1111;
  assign mem_read_enable  = w_is_read & ~w_fifo_full;
  assign mem_write_enable = w_is_write;

  assign inst_wait_req = w_sel_inst ? w_owner_wait : 1'b1;
  assign data_wait_req = w_sel_data ? w_owner_wait : 1'b1;

  // Responses are routed combinationally from the head tag in the same cycle.
  assign w_pop          = mem_valid & ~w_fifo_empty;
  assign inst_valid     = w_pop & (w_head == OWNER_INST);
  assign data_valid     = w_pop & (w_head == OWNER_DATA);
  assign inst_read_data = mem_read_data;
  assign data_read_data = mem_read_data;
  assign protocol_error = r_protocol_error;

  arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clock),
    .rst     (reset),
    .i_push  (w_accept & w_is_read),
    .i_tag   (w_owner),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (outstanding_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lock_valid     <= 1'b0;
      r_lock_owner     <= OWNER_INST;
      r_starve_cnt     <= '0;
      r_protocol_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lock_valid <= 1'b0;
      end else if (w_is_read || w_is_write) begin
        r_lock_valid <= 1'b1;
        r_lock_owner <= w_owner;
      end
      if (!inst_read_enable || (w_accept && w_sel_inst))
        r_starve_cnt <= '0;
      else if (w_accept && w_sel_data && r_starve_cnt != c_stv_w'(STARVE_LIMIT))
        r_starve_cnt <= r_starve_cnt + 1'b1;
      if (mem_valid && w_fifo_empty)
        r_protocol_error <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_unified_bus_arbiter.sv
//------------------------------------------------------------------------------
// tb_unified_bus_arbiter - directed self-checking bench for unified_bus_arbiter.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_unified_bus_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] inst_address;
  logic        inst_read_enable;
  logic [31:0] inst_read_data;
  logic        inst_wait_req;
  logic        inst_valid;
  logic [31:0] data_address;
  logic [31:0] data_write_data;
  logic [3:0]  data_byte_enable;
  logic        data_read_enable;
  logic        data_write_enable;
  logic [31:0] data_read_data;
  logic        data_wait_req;
  logic        data_valid;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;
  logic        mem_wait_req;
  logic        mem_valid;
  logic [1:0]  outstanding_count;
  logic        protocol_error;

  int n_vec = 0;
  int n_err = 0;

  unified_bus_arbiter #(
    .MAX_OUTSTANDING (2),
    .STARVE_LIMIT    (4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .inst_address      (inst_address),
    .inst_read_enable  (inst_read_enable),
    .inst_read_data    (inst_read_data),
    .inst_wait_req     (inst_wait_req),
    .inst_valid        (inst_valid),
    .data_address      (data_address),
    .data_write_data   (data_write_data),
    .data_byte_enable  (data_byte_enable),
    .data_read_enable  (data_read_enable),
    .data_write_enable (data_write_enable),
    .data_read_data    (data_read_data),
    .data_wait_req     (data_wait_req),
    .data_valid        (data_valid),
    .mem_address       (mem_address),
    .mem_write_data    (mem_write_data),
    .mem_byte_enable   (mem_byte_enable),
    .mem_read_enable   (mem_read_enable),
    .mem_write_enable  (mem_write_enable),
    .mem_read_data     (mem_read_data),
    .mem_wait_req      (mem_wait_req),
    .mem_valid         (mem_valid),
    .outstanding_count (outstanding_count),
    .protocol_error    (protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    inst_address      = 32'h0;
    inst_read_enable  = 1'b0;
    data_address      = 32'h0;
    data_write_data   = 32'h0;
    data_byte_enable  = 4'h0;
    data_read_enable  = 1'b0;
    data_write_enable = 1'b0;
    mem_read_data     = 32'h0;
    mem_wait_req      = 1'b0;
    mem_valid         = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_vec++;
    if ({mem_read_enable, mem_write_enable, inst_valid, data_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_enables: got %b expected 0000",
               {mem_read_enable, mem_write_enable, inst_valid, data_valid});
    end
    n_vec++;
    if ({outstanding_count, protocol_error} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_state: got cnt=%0d perr=%b expected cnt=0 perr=0",
               outstanding_count, protocol_error);
    end
    // read in flight, then reset: it must be forgotten
    inst_read_enable = 1'b1;
    inst_address     = 32'h20;
    @(negedge clock);
    idle();
    #1;
    n_vec++;
    if (outstanding_count !== 2'd1) begin
      n_err++;
      $display("FAIL rst_pre_count: got %0d expected 1", outstanding_count);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_vec++;
    if (outstanding_count !== 2'd0) begin
      n_err++;
      $display("FAIL rst_mid_count: got %0d expected 0", outstanding_count);
    end
    mem_valid = 1'b1;
    #1;
    n_vec++;
    if ({inst_valid, data_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_stray_valid: got %b expected 00", {inst_valid, data_valid});
    end
    @(negedge clock);
    mem_valid = 1'b0;
    #1;
    n_vec++;
    if (protocol_error !== 1'b1) begin
      n_err++;
      $display("FAIL rst_stray_perr: got %b expected 1", protocol_error);
    end
  endtask

  task automatic test_inst_reads();
    do_reset();
    inst_read_enable = 1'b1;
    inst_address     = 32'h0;
    #1;
    n_vec++;
    if ({mem_read_enable, mem_write_enable, inst_wait_req, mem_byte_enable, mem_address}
        !== {1'b1, 1'b0, 1'b0, 4'hF, 32'h0}) begin
      n_err++;
      $display("FAIL inst_req0: got re=%b we=%b wr=%b be=%h a=%h expected 1 0 0 f 00000000",
               mem_read_enable, mem_write_enable, inst_wait_req, mem_byte_enable, mem_address);
    end
    @(negedge clock);
    inst_address  = 32'h4;
    mem_valid     = 1'b1;
    mem_read_data = 32'h0000_0013;
    #1;
    n_vec++;
    if ({inst_valid, data_valid, inst_read_data} !== {2'b10, 32'h0000_0013}) begin
      n_err++;
      $display("FAIL inst_rsp0: got iv=%b dv=%b d=%h expected 1 0 00000013",
               inst_valid, data_valid, inst_read_data);
    end
    n_vec++;
    if ({mem_read_enable, mem_address, outstanding_count} !== {1'b1, 32'h4, 2'd1}) begin
      n_err++;
      $display("FAIL inst_req1: got re=%b a=%h cnt=%0d expected 1 00000004 1",
               mem_read_enable, mem_address, outstanding_count);
    end
    @(negedge clock);
    inst_read_enable = 1'b0;
    mem_read_data    = 32'h0010_0093;
    #1;
    n_vec++;
    if ({inst_valid, data_valid, inst_read_data, mem_read_enable}
        !== {2'b10, 32'h0010_0093, 1'b0}) begin
      n_err++;
      $display("FAIL inst_rsp1: got iv=%b dv=%b d=%h re=%b expected 1 0 00100093 0",
               inst_valid, data_valid, inst_read_data, mem_read_enable);
    end
    @(negedge clock);
    mem_valid = 1'b0;
    #1;
    n_vec++;
    if ({outstanding_count, inst_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL inst_drain: got cnt=%0d iv=%b expected 0 0", outstanding_count, inst_valid);
    end
  endtask

  task automatic test_priority();
    do_reset();
    inst_read_enable = 1'b1;
    inst_address     = 32'h200;
    data_read_enable = 1'b1;
    data_address     = 32'h100;
    #1;
    n_vec++;
    if ({mem_address, data_wait_req, inst_wait_req, mem_read_enable}
        !== {32'h100, 1'b0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL prio_data_first: got a=%h dwr=%b iwr=%b re=%b expected 00000100 0 1 1",
               mem_address, data_wait_req, inst_wait_req, mem_read_enable);
    end
    @(negedge clock);
    data_read_enable = 1'b0;
    #1;
    n_vec++;
    if ({mem_address, inst_wait_req, mem_read_enable} !== {32'h200, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL prio_inst_next: got a=%h iwr=%b re=%b expected 00000200 0 1",
               mem_address, inst_wait_req, mem_read_enable);
    end
    @(negedge clock);
    inst_read_enable = 1'b0;
    mem_valid        = 1'b1;
    mem_read_data    = 32'hAAAA_0001;
    #1;
    n_vec++;
    if ({data_valid, inst_valid, data_read_data, outstanding_count}
        !== {2'b10, 32'hAAAA_0001, 2'd2}) begin
      n_err++;
      $display("FAIL prio_rsp_data: got dv=%b iv=%b d=%h cnt=%0d expected 1 0 aaaa0001 2",
               data_valid, inst_valid, data_read_data, outstanding_count);
    end
    @(negedge clock);
    mem_read_data = 32'hBBBB_0002;
    #1;
    n_vec++;
    if ({data_valid, inst_valid, inst_read_data} !== {2'b01, 32'hBBBB_0002}) begin
      n_err++;
      $display("FAIL prio_rsp_inst: got dv=%b iv=%b d=%h expected 0 1 bbbb0002",
               data_valid, inst_valid, inst_read_data);
    end
    @(negedge clock);
    mem_valid = 1'b0;
    #1;
    n_vec++;
    if (outstanding_count !== 2'd0) begin
      n_err++;
      $display("FAIL prio_drain: got %0d expected 0", outstanding_count);
    end
  endtask

  task automatic test_lock();
    do_reset();
    data_write_enable = 1'b1;
    data_address      = 32'h300;
    data_write_data   = 32'hDEAD_BEEF;
    data_byte_enable  = 4'b0011;
    mem_wait_req      = 1'b1;
    #1;
    n_vec++;
    if ({mem_address, mem_write_data, mem_byte_enable, mem_write_enable, data_wait_req}
        !== {32'h300, 32'hDEAD_BEEF, 4'b0011, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL lock_c0: got a=%h wd=%h be=%b we=%b dwr=%b expected 00000300 deadbeef 0011 1 1",
               mem_address, mem_write_data, mem_byte_enable, mem_write_enable, data_wait_req);
    end
    for (int c = 1; c <= 2; c++) begin
      @(negedge clock);
      inst_read_enable = 1'b1;
      inst_address     = 32'h40;
      #1;
      n_vec++;
      if ({mem_address, mem_write_enable, mem_read_enable, inst_wait_req}
          !== {32'h300, 1'b1, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL lock_hold c%0d: got a=%h we=%b re=%b iwr=%b expected 00000300 1 0 1",
                 c, mem_address, mem_write_enable, mem_read_enable, inst_wait_req);
      end
    end
    @(negedge clock);
    mem_wait_req = 1'b0;
    #1;
    n_vec++;
    if ({mem_address, mem_write_enable, data_wait_req, inst_wait_req}
        !== {32'h300, 1'b1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL lock_accept: got a=%h we=%b dwr=%b iwr=%b expected 00000300 1 0 1",
               mem_address, mem_write_enable, data_wait_req, inst_wait_req);
    end
    @(negedge clock);
    data_write_enable = 1'b0;
    #1;
    n_vec++;
    if ({mem_address, mem_read_enable, mem_write_enable, inst_wait_req, mem_byte_enable, mem_write_data}
        !== {32'h40, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0}) begin
      n_err++;
      $display("FAIL lock_inst_after: got a=%h re=%b we=%b iwr=%b be=%h wd=%h expected 00000040 1 0 0 f 0",
               mem_address, mem_read_enable, mem_write_enable, inst_wait_req,
               mem_byte_enable, mem_write_data);
    end
    @(negedge clock);
    idle();
  endtask

  task automatic test_starve();
    do_reset();
    inst_read_enable = 1'b1;
    inst_address     = 32'h80;
    data_read_enable = 1'b1;
    data_address     = 32'h500;
    for (int k = 0; k < 4; k++) begin
      mem_valid     = (k > 0);
      mem_read_data = 32'h5000 + k;
      #1;
      n_vec++;
      if ({mem_address, data_wait_req, inst_wait_req, data_valid}
          !== {32'h500, 1'b0, 1'b1, (k > 0)}) begin
        n_err++;
        $display("FAIL starve_data k%0d: got a=%h dwr=%b iwr=%b dv=%b expected 00000500 0 1 %b",
                 k, mem_address, data_wait_req, inst_wait_req, data_valid, (k > 0));
      end
      @(negedge clock);
    end
    mem_valid = 1'b1;
    #1;
    n_vec++;
    if ({mem_address, inst_wait_req, data_wait_req, data_valid}
        !== {32'h80, 1'b0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL starve_force_inst: got a=%h iwr=%b dwr=%b dv=%b expected 00000080 0 1 1",
               mem_address, inst_wait_req, data_wait_req, data_valid);
    end
    @(negedge clock);
    inst_address  = 32'h84;
    mem_read_data = 32'h1234_5678;
    #1;
    n_vec++;
    if ({mem_address, data_wait_req, inst_wait_req, inst_valid, inst_read_data}
        !== {32'h500, 1'b0, 1'b1, 1'b1, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL starve_cleared: got a=%h dwr=%b iwr=%b iv=%b d=%h expected 00000500 0 1 1 12345678",
               mem_address, data_wait_req, inst_wait_req, inst_valid, inst_read_data);
    end
    @(negedge clock);
    idle();
    mem_valid = 1'b1;
    #1;
    n_vec++;
    if ({data_valid, inst_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL starve_last_rsp: got dv=%b iv=%b expected 1 0", data_valid, inst_valid);
    end
    @(negedge clock);
    mem_valid = 1'b0;
  endtask

  task automatic test_outstanding();
    do_reset();
    data_read_enable = 1'b1;
    data_address     = 32'h600;
    @(negedge clock);
    data_address = 32'h604;
    @(negedge clock);
    data_read_enable  = 1'b0;
    data_write_enable = 1'b1;
    data_address      = 32'h700;
    data_write_data   = 32'h0BAD_F00D;
    data_byte_enable  = 4'hF;
    #1;
    n_vec++;
    if ({outstanding_count, mem_write_enable, data_wait_req, mem_address}
        !== {2'd2, 1'b1, 1'b0, 32'h700}) begin
      n_err++;
      $display("FAIL full_write_ok: got cnt=%0d we=%b dwr=%b a=%h expected 2 1 0 00000700",
               outstanding_count, mem_write_enable, data_wait_req, mem_address);
    end
    @(negedge clock);
    data_write_enable = 1'b0;
    inst_read_enable  = 1'b1;
    inst_address      = 32'h10;
    #1;
    n_vec++;
    if ({inst_wait_req, mem_read_enable, outstanding_count} !== {1'b1, 1'b0, 2'd2}) begin
      n_err++;
      $display("FAIL full_read_blocked: got iwr=%b re=%b cnt=%0d expected 1 0 2",
               inst_wait_req, mem_read_enable, outstanding_count);
    end
    @(negedge clock);
    mem_valid     = 1'b1;
    mem_read_data = 32'h6000_0000;
    #1;
    n_vec++;
    if ({data_valid, inst_wait_req, mem_read_enable} !== {1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL full_no_bypass: got dv=%b iwr=%b re=%b expected 1 1 0",
               data_valid, inst_wait_req, mem_read_enable);
    end
    @(negedge clock);
    mem_valid = 1'b0;
    #1;
    n_vec++;
    if ({inst_wait_req, mem_read_enable, mem_address, outstanding_count}
        !== {1'b0, 1'b1, 32'h10, 2'd1}) begin
      n_err++;
      $display("FAIL full_released: got iwr=%b re=%b a=%h cnt=%0d expected 0 1 00000010 1",
               inst_wait_req, mem_read_enable, mem_address, outstanding_count);
    end
    @(negedge clock);
    inst_read_enable = 1'b0;
    mem_valid        = 1'b1;
    #1;
    n_vec++;
    if ({data_valid, inst_valid, outstanding_count} !== {2'b10, 2'd2}) begin
      n_err++;
      $display("FAIL full_rsp_data: got dv=%b iv=%b cnt=%0d expected 1 0 2",
               data_valid, inst_valid, outstanding_count);
    end
    @(negedge clock);
    #1;
    n_vec++;
    if ({data_valid, inst_valid} !== 2'b01) begin
      n_err++;
      $display("FAIL full_rsp_inst: got dv=%b iv=%b expected 0 1", data_valid, inst_valid);
    end
    @(negedge clock);
    mem_valid = 1'b0;
  endtask

  task automatic test_protocol_error();
    do_reset();
    mem_valid = 1'b1;
    #1;
    n_vec++;
    if ({inst_valid, data_valid, protocol_error} !== 3'b000) begin
      n_err++;
      $display("FAIL perr_stray: got iv=%b dv=%b perr=%b expected 0 0 0",
               inst_valid, data_valid, protocol_error);
    end
    @(negedge clock);
    mem_valid = 1'b0;
    #1;
    n_vec++;
    if (protocol_error !== 1'b1) begin
      n_err++;
      $display("FAIL perr_set: got %b expected 1", protocol_error);
    end
    inst_read_enable = 1'b1;
    @(negedge clock);
    inst_read_enable = 1'b0;
    mem_valid        = 1'b1;
    @(negedge clock);
    mem_valid = 1'b0;
    @(negedge clock);
    #1;
    n_vec++;
    if (protocol_error !== 1'b1) begin
      n_err++;
      $display("FAIL perr_sticky: got %b expected 1", protocol_error);
    end
    do_reset();
    #1;
    n_vec++;
    if (protocol_error !== 1'b0) begin
      n_err++;
      $display("FAIL perr_cleared: got %b expected 0", protocol_error);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_inst_reads();
    test_priority();
    test_lock();
    test_starve();
    test_outstanding();
    test_protocol_error();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
